// File: rtl/sr_seq_pkg.sv
// Shared types and constants for the SR command sequencer.
package sr_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        QUAL     = 3'd1,
        DRIVE    = 3'd2,
        GUARD    = 3'd3,
        WAIT_REL = 3'd4
    } state_e;

    // Direction latched for the command in flight.
    localparam logic DIR_SET = 1'b1;
    localparam logic DIR_CLR = 1'b0;

    // Largest value an unsigned counter of the given width can hold.
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sr_debounce_cnt.sv
// Saturating up-counter with synchronous clear. The done flag reports that
// the count being loaded on the coming edge equals THRESH, so the caller can
// change state on the same edge the threshold is reached.
module sr_debounce_cnt #(
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned THRESH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment; increment saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_d == THRESH[CNT_W-1:0]);

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Command sequencer for the master-slave SR flip-flop: debounces raw set/clear
// requests, issues one fixed-width S or R pulse per press, never drives S and
// R together, and tracks the expected flip-flop state in q_exp.
module sr_cmd_sequencer
    import sr_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES     = 2,
    parameter int unsigned CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic s,
    output logic r,
    output logic busy,
    output logic q_exp,
    output logic conflict
);

    localparam int unsigned CNT_LIMIT = cnt_max(CNT_W);

    // Both thresholds must fit in the counters, which saturate rather than wrap.
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > CNT_LIMIT) begin : g_bad_debounce
        $error("sr_cmd_sequencer: DEBOUNCE_CYCLES out of range 1..2^CNT_W-1");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_LIMIT) begin : g_bad_hold
        $error("sr_cmd_sequencer: HOLD_CYCLES out of range 1..2^CNT_W-1");
    end

    state_e state_q;
    state_e state_d;
    logic   dir_q;
    logic   dir_d;

    logic   s_q;
    logic   s_d;
    logic   r_q;
    logic   r_d;
    logic   busy_q;
    logic   busy_d;
    logic   q_exp_q;
    logic   q_exp_d;
    logic   conflict_q;
    logic   conflict_d;

    logic   lone_req;
    logic   both_req;
    logic   latched_hi;
    logic   other_hi;
    logic   qual_clean;

    logic   dcnt_inc;
    logic   dcnt_clr;
    logic   dcnt_done;
    logic   hcnt_inc;
    logic   hcnt_clr;
    logic   hcnt_done;

    assign lone_req   = set_req ^ clr_req;
    assign both_req   = set_req & clr_req;
    assign latched_hi = (dir_q == DIR_SET) ? set_req : clr_req;
    assign other_hi   = (dir_q == DIR_SET) ? clr_req : set_req;
    assign qual_clean = latched_hi & ~other_hi;

    // The first accepted sample in IDLE already counts as one debounce sample.
    assign dcnt_inc = ((state_q == IDLE) && lone_req) || ((state_q == QUAL) && qual_clean);
    assign dcnt_clr = ~dcnt_inc;
    assign hcnt_inc = (state_q == DRIVE);
    assign hcnt_clr = ~hcnt_inc;

    sr_debounce_cnt #(
        .CNT_W  (CNT_W),
        .THRESH (DEBOUNCE_CYCLES)
    ) u_dcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (dcnt_clr),
        .inc  (dcnt_inc),
        .done (dcnt_done)
    );

    sr_debounce_cnt #(
        .CNT_W  (CNT_W),
        .THRESH (HOLD_CYCLES)
    ) u_hcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (hcnt_clr),
        .inc  (hcnt_inc),
        .done (hcnt_done)
    );

    // State and registered outputs; reset forces s/r low on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dir_q      <= DIR_CLR;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            q_exp_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            q_exp_q    <= q_exp_d;
            conflict_q <= conflict_d;
        end
    end

    // Next-state logic and direction latch.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        unique case (state_q)
            IDLE: begin
                if (lone_req) begin
                    dir_d   = set_req ? DIR_SET : DIR_CLR;
                    state_d = dcnt_done ? DRIVE : QUAL;
                end
            end
            QUAL: begin
                if (other_hi || !latched_hi) begin
                    state_d = IDLE;
                end else if (dcnt_done) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (hcnt_done) begin
                    state_d = GUARD;
                end
            end
            GUARD: begin
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!set_req && !clr_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        s_d        = (state_d == DRIVE) && (dir_d == DIR_SET);
        r_d        = (state_d == DRIVE) && (dir_d == DIR_CLR);
        busy_d     = (state_d != IDLE);
        q_exp_d    = q_exp_q;
        if ((state_q == DRIVE) && hcnt_done) begin
            q_exp_d = dir_q;
        end
        conflict_d = ((state_q == IDLE) && both_req) || ((state_q == QUAL) && other_hi);
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign q_exp    = q_exp_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Scoreboard bench for sr_cmd_sequencer: directed scenarios followed by
// randomized request bursts, checked cycle by cycle against a reference model.
module tb_sr_cmd_sequencer;

    localparam int unsigned D = 4;
    localparam int unsigned H = 2;
    localparam int unsigned W = 3;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic s;
    logic r;
    logic busy;
    logic q_exp;
    logic conflict;

    sr_cmd_sequencer #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .CNT_W           (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .q_exp    (q_exp),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic s;
        logic r;
        logic busy;
        logic q;
        logic conflict;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: a pending press with its run of clean samples, the
    // number of pulse cycles still owed, the one-cycle gap, and a wait for release.
    int unsigned m_run   = 0;
    bit          m_dir   = 1'b0;
    int unsigned m_left  = 0;
    bit          m_guard = 1'b0;
    bit          m_wait  = 1'b0;
    bit          m_q     = 1'b0;

    function automatic exp_t model_step(input bit rs, input bit st, input bit cl);
        exp_t e;
        bit   mine;
        bit   other;
        bit   cf;
        cf = 1'b0;
        if (rs) begin
            m_run = 0; m_left = 0; m_guard = 0; m_wait = 0; m_q = 0; m_dir = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_q     = m_dir;
                m_guard = 1'b1;
            end
        end else if (m_guard) begin
            m_guard = 1'b0;
            m_wait  = 1'b1;
        end else if (m_wait) begin
            if (!st && !cl) m_wait = 1'b0;
        end else if (m_run > 0) begin
            mine  = m_dir ? st : cl;
            other = m_dir ? cl : st;
            if (other) begin
                m_run = 0;
                cf    = 1'b1;
            end else if (!mine) begin
                m_run = 0;
            end else begin
                m_run = m_run + 1;
                if (m_run == D) begin
                    m_run  = 0;
                    m_left = H;
                end
            end
        end else begin
            if (st && cl) begin
                cf = 1'b1;
            end else if (st != cl) begin
                m_dir = st;
                m_run = 1;
                if (D == 1) begin
                    m_run  = 0;
                    m_left = H;
                end
            end
        end
        e.s        = (m_left > 0) && m_dir;
        e.r        = (m_left > 0) && !m_dir;
        e.busy     = (m_run > 0) || (m_left > 0) || m_guard || m_wait;
        e.q        = m_q;
        e.conflict = cf;
        return e;
    endfunction

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One stimulus cycle: drive on the falling edge, queue the expectation
    // for the following rising edge.
    task automatic cyc(input bit rs, input bit st, input bit cl);
        @(negedge clk);
        rst     = rs;
        set_req = st;
        clr_req = cl;
        exp_q.push_back(model_step(rs, st, cl));
    endtask

    task automatic hold(input int unsigned n, input bit st, input bit cl);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, st, cl);
    endtask

    // Monitor: compare every rising-edge result with the queued expectation,
    // and independently measure each s/r pulse width.
    initial begin
        exp_t        e;
        int unsigned width;
        width = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("s", s, e.s);
                chk("r", r, e.r);
                chk("busy", busy, e.busy);
                chk("q_exp", q_exp, e.q);
                chk("conflict", conflict, e.conflict);
                chk("s_r_exclusive", s & r, 1'b0);
                if (rst) begin
                    width = 0;
                end else if (s | r) begin
                    width++;
                end else if (width != 0) begin
                    chk_int("pulse_width", int'(width), int'(H));
                    width = 0;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int unsigned len;
        int unsigned pick;
        bit          st;
        bit          cl;
        bit          rs;

        // Reset held with set_req high, then release with set_req still high.
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        hold(8, 1'b1, 1'b0);
        hold(3, 1'b0, 1'b0);

        // Clean set (repeat while q_exp=1), then clean clear.
        hold(10, 1'b1, 1'b0);
        hold(3, 1'b0, 1'b0);
        hold(8, 1'b0, 1'b1);
        hold(3, 1'b0, 1'b0);

        // Bounce: 2 high, 1 low, 6 high.
        hold(2, 1'b1, 1'b0);
        hold(1, 1'b0, 1'b0);
        hold(6, 1'b1, 1'b0);
        hold(3, 1'b0, 1'b0);

        // Collision in IDLE, then opposite request during qualification.
        hold(1, 1'b1, 1'b1);
        hold(2, 1'b0, 1'b0);
        hold(2, 1'b1, 1'b0);
        hold(1, 1'b1, 1'b1);
        hold(3, 1'b0, 1'b0);
        hold(2, 1'b0, 1'b1);
        hold(1, 1'b1, 1'b1);
        hold(3, 1'b0, 1'b0);

        // Reset during the second cycle of an s pulse.
        hold(4, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        hold(4, 1'b0, 1'b0);

        // Randomized bursts with occasional reset.
        for (int n = 0; n < 2000; n++) begin
            len  = $urandom_range(1, 8);
            pick = $urandom_range(0, 9);
            st   = (pick < 4) || (pick == 7);
            cl   = ((pick >= 4) && (pick < 7)) || (pick == 7);
            rs   = ($urandom_range(0, 99) == 0);
            for (int unsigned k = 0; k < len; k++) begin
                cyc(rs && (k == 0), st, cl);
            end
        end
        hold(4, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk_int("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_cmd_sequencer.md
Name: sr_cmd_sequencer

Overview:
- Upstream command stage for the master-slave SR flip-flop.
- Converts raw, possibly bouncy set/clear request lines into clean S/R drive pulses.
- Guarantees the illegal S=R=1 combination is never issued.
- Tracks the expected flip-flop output (q_exp) so downstream logic and the verification bench can compare it against the real q.

Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive high samples a lone request needs before it is accepted. Legal range 1..(2^CNT_W - 1).
- HOLD_CYCLES, default 2: number of clk cycles s or r is held high per command. Minimum 1.
- CNT_W, default 3: width of the debounce counter and the hold counter.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- set_req  input  1  raw set request (asynchronous to nothing; sampled on clk).
- clr_req  input  1  raw clear request.
- s  output  1  registered set drive to the flip-flop.
- r  output  1  registered reset drive to the flip-flop.
- busy  output  1  high whenever the FSM is not in IDLE.
- q_exp  output  1  expected flip-flop state after the last completed command.
- conflict  output  1  one-cycle pulse when set_req and clr_req collide.

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset (rst) is synchronous and active-high.
  - With rst sampled high: state=IDLE, s=0, r=0, busy=0, q_exp=0, conflict=0, both counters=0.
  - rst overrides everything, including mid-DRIVE. s and r go low on that same edge.
- Registered outputs: all outputs are registered. s and r are mutually exclusive in every cycle, including across reset.
- States: IDLE, QUAL, DRIVE, GUARD, WAIT_REL.
- IDLE:
  - Exactly one request high: latch dir (1=set, 0=clear), set dcnt=1, go to QUAL. If DEBOUNCE_CYCLES==1, go directly to DRIVE instead.
  - Both requests high: conflict=1 for one cycle, stay in IDLE.
  - Neither request high: stay in IDLE.
- QUAL:
  - Latched request still high and opposite request low: dcnt++. When dcnt reaches DEBOUNCE_CYCLES, go to DRIVE.
  - Latched request low: return to IDLE, dcnt=0, no conflict.
  - Opposite request high: return to IDLE, dcnt=0, conflict=1 for one cycle.
- DRIVE:
  - s=dir and r=!dir, held for exactly HOLD_CYCLES cycles (hcnt counts).
  - Requests are ignored.
  - On the final hold edge: q_exp=dir, go to GUARD.
- GUARD: s=r=0 for exactly 1 cycle, then go to WAIT_REL.
- WAIT_REL:
  - Stay until set_req=0 and clr_req=0 in the same sample, then go to IDLE.
  - This enforces one command per press.
- busy: 1 in QUAL, DRIVE, GUARD and WAIT_REL.
- Latency: a lone request first sampled high at edge k, staying clean, causes s (or r) to rise at edge k+DEBOUNCE_CYCLES-1 and fall at edge k+DEBOUNCE_CYCLES-1+HOLD_CYCLES.
- Repeat commands: a repeated set while q_exp=1 is still fully sequenced. q_exp is unchanged.
- Counters: saturate and never wrap. A parameter check (elaboration assertion) rejects DEBOUNCE_CYCLES or HOLD_CYCLES > 2^CNT_W - 1.

Decomposition:
- Package sr_seq_pkg holds:
  - the state enumeration (IDLE, QUAL, DRIVE, GUARD, WAIT_REL);
  - the dir encoding constants DIR_SET=1 and DIR_CLR=0.
- One sub-module is natural: sr_debounce_cnt.
  - Behaviour: saturating up-counter with synchronous clear and a terminal-count flag at DEBOUNCE_CYCLES.
  - Ports: clk, rst, clr, inc, done.
  - The hold counter reuses it with the HOLD_CYCLES threshold.

Test Plan:
- Reset: assert rst for 2 cycles with set_req=1 -> s=r=busy=q_exp=conflict=0 throughout. After release, s rises exactly DEBOUNCE_CYCLES-1 edges after the first post-reset sample.
- Clean set, defaults (4/2): set_req held high 10 cycles from edge 0 -> s=1 after edges 3..4, s=0 at edge 5, q_exp=1 from edge 5, busy stays high until 1 cycle after set_req drops.
- Bounce: set_req high for 2 cycles, low for 1, high for 6 -> no s pulse from the first burst. s rises 3 edges after the second burst begins. conflict stays 0.
- Collision: set_req and clr_req rise on the same edge in IDLE -> conflict=1 for exactly 1 cycle, s=r=0, state stays IDLE. Assert clr_req during QUAL of a set -> conflict pulse, return to IDLE.
- Reset mid-DRIVE: rst asserted on the second cycle of s high -> s=0 on the next edge, q_exp=0 (not updated).
- Stress: random set_req/clr_req for 10k cycles -> s&&r never 1, and every s/r pulse is exactly HOLD_CYCLES wide.
